// File: rtl/decimal_entry_pkg.sv
// decimal_entry_pkg: shared constants and FSM state type for the decimal entry block
package decimal_entry_pkg;
    localparam int NUM_DIGITS = 6;
    localparam int VALUE_W    = 20;
    localparam int DIGITS_W   = 4 * NUM_DIGITS;
    localparam int COUNT_W    = 3;
    localparam int POS_W      = $clog2(NUM_DIGITS);
    localparam logic [3:0] BLANK = 4'hF;
    localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(NUM_DIGITS);
    localparam logic [DIGITS_W-1:0] ALL_BLANK = {NUM_DIGITS{BLANK}};
    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
endpackage

// File: rtl/decimal_entry_if.sv
// decimal_entry_if: keypad-side strobes in, BCD echo and converted value out
//   master: drives digit_valid/digit/enter/clear, observes digits/count/busy/done/value
//   slave : the decimal_entry block
interface decimal_entry_if;
    import decimal_entry_pkg::*;
    logic                digit_valid;
    logic [3:0]          digit;
    logic                enter;
    logic                clear;
    logic [DIGITS_W-1:0] digits;
    logic [COUNT_W-1:0]  count;
    logic                busy;
    logic                done;
    logic [VALUE_W-1:0]  value;
    modport master (output digit_valid, digit, enter, clear, input digits, count, busy, done, value);
    modport slave  (input digit_valid, digit, enter, clear, output digits, count, busy, done, value);
endinterface

// File: rtl/decimal_entry_mac10.sv
// decimal_entry_mac10: combinational acc*10 + digit, truncated to VALUE_W
//   acc_i   : running binary accumulator
//   digit_i : BCD digit to append
//   sum_o   : acc_i*10 + digit_i
module decimal_entry_mac10
    import decimal_entry_pkg::*;
(
    input  logic [VALUE_W-1:0] acc_i,
    input  logic [3:0]         digit_i,
    output logic [VALUE_W-1:0] sum_o
);
    // *10 built from two shifts so no multiplier is inferred
    assign sum_o = (acc_i << 3) + (acc_i << 1) + VALUE_W'(digit_i);
endmodule

// File: rtl/decimal_entry.sv
// decimal_entry: collects up to six BCD digits and converts them serially to binary on enter
//   clk_i   : system clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : slave side of decimal_entry_if (key strobes in, echo/count/busy/done/value out)
module decimal_entry
    import decimal_entry_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_n_i,
    decimal_entry_if.slave bus
);
    state_t              state_q;
    logic [DIGITS_W-1:0] digits_q;
    logic [COUNT_W-1:0]  count_q;
    logic [VALUE_W-1:0]  value_q;
    logic [VALUE_W-1:0]  acc_q;
    logic [VALUE_W-1:0]  acc_d;
    logic [POS_W-1:0]    idx_q;
    logic                busy_q;
    logic                done_q;

    // most significant stored digit is converted first; idx walks down to the last typed digit
    decimal_entry_mac10 u_mac10 (
        .acc_i   (acc_q),
        .digit_i (digits_q[4*idx_q +: 4]),
        .sum_o   (acc_d)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            digits_q <= ALL_BLANK;
            count_q  <= '0;
            value_q  <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.clear) begin
                        digits_q <= ALL_BLANK;
                        count_q  <= '0;
                    end else if (bus.enter) begin
                        busy_q <= 1'b1;
                        if (count_q == '0) begin
                            value_q <= '0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            acc_q   <= '0;
                            idx_q   <= POS_W'(count_q - COUNT_W'(1));
                            state_q <= CONVERT;
                        end
                    end else if (bus.digit_valid && bus.digit <= 4'd9 && count_q < MAX_COUNT) begin
                        digits_q <= {digits_q[DIGITS_W-5:0], bus.digit};
                        count_q  <= count_q + COUNT_W'(1);
                    end
                end
                CONVERT: begin
                    if (idx_q == '0) begin
                        value_q <= acc_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        acc_q <= acc_d;
                        idx_q <= idx_q - POS_W'(1);
                    end
                end
                DONE: begin
                    digits_q <= ALL_BLANK;
                    count_q  <= '0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.digits = digits_q;
    assign bus.count  = count_q;
    assign bus.value  = value_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_decimal_entry.sv
// tb_decimal_entry: directed self-checking bench for decimal_entry
module tb_decimal_entry;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int passed = 0;

    decimal_entry_if bus();

    decimal_entry dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit = d;
        tick();
        bus.digit_valid = 1'b0;
        bus.digit = 4'd0;
    endtask

    // observe from the sample right after the enter edge; bounded to 20 cycles
    task automatic watch(output int busy_n, output int done_at, output int pulses);
        busy_n = 0;
        done_at = -1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                pulses++;
                if (done_at < 0) done_at = k;
            end
            tick();
        end
    endtask

    task automatic do_enter(output int busy_n, output int done_at, output int pulses);
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        watch(busy_n, done_at, pulses);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (bus.digits !== 24'hFFFFFF) $display("FAIL reset_digits: got %h expected ffffff", bus.digits); else passed++;
        checks++; if (bus.count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", bus.count); else passed++;
        checks++; if (bus.value !== 20'd0) $display("FAIL reset_value: got %h expected 0", bus.value); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int b, d, p;
        press(4'd1); press(4'd2); press(4'd3);
        checks++; if (bus.digits !== 24'hFFF123) $display("FAIL basic_digits: got %h expected fff123", bus.digits); else passed++;
        checks++; if (bus.count !== 3'd3) $display("FAIL basic_count: got %0d expected 3", bus.count); else passed++;
        do_enter(b, d, p);
        checks++; if (b != 4) $display("FAIL basic_busy_cycles: got %0d expected 4", b); else passed++;
        checks++; if (d != 3) $display("FAIL basic_done_latency: got %0d expected 3", d); else passed++;
        checks++; if (p != 1) $display("FAIL basic_done_pulses: got %0d expected 1", p); else passed++;
        checks++; if (bus.value !== 20'h0007B) $display("FAIL basic_value: got %h expected 0007b", bus.value); else passed++;
        checks++; if (bus.digits !== 24'hFFFFFF) $display("FAIL basic_digits_after: got %h expected ffffff", bus.digits); else passed++;
        checks++; if (bus.count !== 3'd0) $display("FAIL basic_count_after: got %0d expected 0", bus.count); else passed++;
    endtask

    task automatic test_full();
        int b, d, p;
        repeat (7) press(4'd9);
        checks++; if (bus.count !== 3'd6) $display("FAIL full_count: got %0d expected 6", bus.count); else passed++;
        checks++; if (bus.digits !== 24'h999999) $display("FAIL full_digits: got %h expected 999999", bus.digits); else passed++;
        do_enter(b, d, p);
        checks++; if (b != 7) $display("FAIL full_busy_cycles: got %0d expected 7", b); else passed++;
        checks++; if (d != 6) $display("FAIL full_done_latency: got %0d expected 6", d); else passed++;
        checks++; if (bus.value !== 20'hF423F) $display("FAIL full_value: got %h expected f423f", bus.value); else passed++;
    endtask

    task automatic test_illegal();
        int b, d, p;
        press(4'd0); press(4'd0);
        press(4'hA);
        checks++; if (bus.count !== 3'd2) $display("FAIL illegal_count: got %0d expected 2", bus.count); else passed++;
        press(4'd4); press(4'd2);
        checks++; if (bus.digits !== 24'hFF0042) $display("FAIL illegal_digits: got %h expected ff0042", bus.digits); else passed++;
        do_enter(b, d, p);
        checks++; if (d != 4) $display("FAIL illegal_done_latency: got %0d expected 4", d); else passed++;
        checks++; if (bus.value !== 20'd42) $display("FAIL illegal_value: got %0d expected 42", bus.value); else passed++;
    endtask

    task automatic test_clear_empty();
        int b, d, p;
        press(4'd7);
        bus.clear = 1'b1;
        bus.digit_valid = 1'b1;
        bus.digit = 4'd5;
        tick();
        bus.clear = 1'b0;
        bus.digit_valid = 1'b0;
        checks++; if (bus.count !== 3'd0) $display("FAIL clear_count: got %0d expected 0", bus.count); else passed++;
        checks++; if (bus.digits !== 24'hFFFFFF) $display("FAIL clear_digits: got %h expected ffffff", bus.digits); else passed++;
        checks++; if (bus.value !== 20'd42) $display("FAIL clear_value_kept: got %0d expected 42", bus.value); else passed++;
        do_enter(b, d, p);
        checks++; if (d != 0) $display("FAIL empty_done_latency: got %0d expected 0", d); else passed++;
        checks++; if (b != 1) $display("FAIL empty_busy_cycles: got %0d expected 1", b); else passed++;
        checks++; if (bus.value !== 20'd0) $display("FAIL empty_value: got %0d expected 0", bus.value); else passed++;
    endtask

    task automatic test_midconvert();
        int b, d, p;
        press(4'd6); press(4'd5); press(4'd4); press(4'd3); press(4'd2); press(4'd1);
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        bus.clear = 1'b1;
        bus.digit_valid = 1'b1;
        bus.digit = 4'd7;
        tick();
        bus.clear = 1'b0;
        bus.digit_valid = 1'b0;
        checks++; if (bus.digits !== 24'h654321) $display("FAIL mid_digits_stable: got %h expected 654321", bus.digits); else passed++;
        checks++; if (bus.count !== 3'd6) $display("FAIL mid_count_stable: got %0d expected 6", bus.count); else passed++;
        watch(b, d, p);
        checks++; if (d != 5) $display("FAIL mid_done_latency: got %0d expected 5", d); else passed++;
        checks++; if (bus.value !== 20'h9FBF1) $display("FAIL mid_value: got %h expected 9fbf1", bus.value); else passed++;
    endtask

    task automatic test_reset_midconvert();
        int b, d, p;
        press(4'd1); press(4'd2); press(4'd3);
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        tick();
        checks++; if (bus.busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected 1", bus.busy); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.digits !== 24'hFFFFFF) $display("FAIL rstmid_digits: got %h expected ffffff", bus.digits); else passed++;
        checks++; if (bus.count !== 3'd0) $display("FAIL rstmid_count: got %0d expected 0", bus.count); else passed++;
        checks++; if (bus.value !== 20'd0) $display("FAIL rstmid_value: got %h expected 0", bus.value); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL rstmid_done: got %b expected 0", bus.done); else passed++;
        tick();
        rst_n = 1'b1;
        watch(b, d, p);
        checks++; if (p != 0) $display("FAIL rstmid_no_done: got %0d pulses expected 0", p); else passed++;
        checks++; if (b != 0) $display("FAIL rstmid_no_busy: got %0d busy cycles expected 0", b); else passed++;
    endtask

    initial begin
        bus.digit_valid = 1'b0;
        bus.digit = 4'd0;
        bus.enter = 1'b0;
        bus.clear = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_illegal();
        test_clear_empty();
        test_midconvert();
        test_reset_midconvert();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
